// File: rtl/axis_fifo_in_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_fifo_in_sync_pkg
// Description : Shared defaults and helpers for the single-clock AXI4-Stream
//               input FIFO that feeds the S2MM write engine.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_fifo_in_sync_pkg;

    localparam int c_DATA_WIDTH_DEFAULT = 32;
    localparam int c_DEPTH_DEFAULT      = 512;

    // Ceiling log2, usable in constant expressions for address widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : axis_fifo_ram
// Description : Simple dual-port storage, DEPTH x DATA_WIDTH. Registered write
//               port, asynchronous read port so the FIFO head is visible in
//               the same cycle its read address changes (FWFT).
// Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo_ram
    import axis_fifo_in_sync_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = c_DEPTH_DEFAULT,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    // Storage is intentionally left unreset so it maps onto RAM primitives;
    // the FIFO never exposes a word that was not written since reset.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port: store one word per enabled clock edge.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/axis_fifo_in_sync.sv
`default_nettype none
// ============================================================================
// Module      : axis_fifo_in_sync
// Description : Single-clock first-word-fall-through AXI4-Stream FIFO that
//               buffers video pixels ahead of the S2MM burst logic. Provides
//               registered occupancy counts and an almost-empty flag.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo_in_sync
    import axis_fifo_in_sync_pkg::*;
#(
    parameter int DATA_WIDTH         = c_DATA_WIDTH_DEFAULT,
    parameter int DEPTH              = c_DEPTH_DEFAULT,
    parameter int ALMOST_EMPTY_LEVEL = 1
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  almost_empty,
    output logic [31:0]           axis_wr_data_count,
    output logic [31:0]           axis_rd_data_count
);

    localparam int          c_ADDR_W   = clog2(DEPTH);
    localparam int          c_PTR_W    = c_ADDR_W + 1;
    localparam logic [31:0] c_AE_LEVEL = 32'(ALMOST_EMPTY_LEVEL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_count;
    logic                  r_s_tready;
    logic                  r_m_tvalid;
    logic                  r_almost_empty;

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [c_PTR_W-1:0]    w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]    w_rd_ptr_nxt;
    logic [c_PTR_W-1:0]    w_count_nxt;
    logic                  w_full_nxt;
    logic                  w_empty_nxt;
    logic                  w_almost_empty_nxt;
    logic [DATA_WIDTH-1:0] w_ram_rd_data;

    // A handshake only counts when the side presenting it is actually able
    // to take part, so writes while full and pops while empty fall away here.
    assign w_wr_en = s_axis_tvalid && r_s_tready;
    assign w_rd_en = r_m_tvalid && m_axis_tready;

    // Post-edge pointer, occupancy and flag values; the registered outputs
    // all load from these so they describe the FIFO after this edge.
    always_comb begin
        w_wr_ptr_nxt       = r_wr_ptr + {{(c_PTR_W-1){1'b0}}, w_wr_en};
        w_rd_ptr_nxt       = r_rd_ptr + {{(c_PTR_W-1){1'b0}}, w_rd_en};
        w_count_nxt        = w_wr_ptr_nxt - w_rd_ptr_nxt;
        w_empty_nxt        = (w_wr_ptr_nxt == w_rd_ptr_nxt);
        w_full_nxt         = (w_wr_ptr_nxt[c_ADDR_W] != w_rd_ptr_nxt[c_ADDR_W]) &&
                             (w_wr_ptr_nxt[c_ADDR_W-1:0] == w_rd_ptr_nxt[c_ADDR_W-1:0]);
        w_almost_empty_nxt = (32'(w_count_nxt) <= c_AE_LEVEL);
    end

    // Pointer, occupancy and handshake flag registers.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_s_tready     <= 1'b0;
            r_m_tvalid     <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_s_tready     <= !w_full_nxt;
            r_m_tvalid     <= !w_empty_nxt;
            r_almost_empty <= w_almost_empty_nxt;
        end
    end

    axis_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (c_ADDR_W)
    ) u_ram (
        .clk        (s_axis_aclk),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (r_wr_ptr[c_ADDR_W-1:0]),
        .i_wr_data  (s_axis_tdata),
        .i_rd_addr  (r_rd_ptr[c_ADDR_W-1:0]),
        .o_rd_data  (w_ram_rd_data)
    );

    // The head is forced to zero while nothing is valid so reset and empty
    // states never expose uninitialised or stale storage.
    assign m_axis_tdata       = r_m_tvalid ? w_ram_rd_data : '0;
    assign m_axis_tvalid      = r_m_tvalid;
    assign s_axis_tready      = r_s_tready;
    assign almost_empty       = r_almost_empty;
    assign axis_wr_data_count = 32'(r_count);
    assign axis_rd_data_count = 32'(r_count);

endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_in_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_fifo_in_sync
// Description : Scoreboard bench for axis_fifo_in_sync at DEPTH=16. A queue
//               model of the FIFO contents and occupancy runs beside the DUT;
//               a monitor compares the DUT outputs against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_fifo_in_sync;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AEL   = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          ae;
    logic [31:0]   wr_cnt;
    logic [31:0]   rd_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: expected contents in arrival order, occupancy, and
    // whether the slave side is currently able to accept.
    logic [DW-1:0] exp_q[$];
    int            occ = 0;
    bit            mdl_ready = 1'b0;
    bit            wr_acc = 1'b0;
    bit            rd_acc = 1'b0;

    axis_fifo_in_sync #(
        .DATA_WIDTH         (DW),
        .DEPTH              (DEPTH),
        .ALMOST_EMPTY_LEVEL (AEL)
    ) dut (
        .s_axis_aclk        (clk),
        .s_axis_aresetn     (rst_n),
        .s_axis_tvalid      (s_tvalid),
        .s_axis_tready      (s_tready),
        .s_axis_tdata       (s_tdata),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tready      (m_tready),
        .m_axis_tdata       (m_tdata),
        .almost_empty       (ae),
        .axis_wr_data_count (wr_cnt),
        .axis_rd_data_count (rd_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each edge; stimulus pushes expected words here.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       = 0;
            mdl_ready = 1'b0;
            wr_acc    = 1'b0;
            rd_acc    = 1'b0;
            exp_q.delete();
        end else begin
            wr_acc = s_tvalid && mdl_ready;
            rd_acc = m_tready && (occ > 0);
            if (wr_acc) exp_q.push_back(s_tdata);
            occ = occ + int'(wr_acc) - int'(rd_acc);
            mdl_ready = (occ < DEPTH);
        end
    end

    // Monitor: compare flags/counts, check the head, pop on accepted reads.
    always @(negedge clk) begin
        chk("m_tvalid", 32'(m_tvalid), 32'(occ != 0));
        chk("s_tready", 32'(s_tready), 32'(mdl_ready));
        chk("wr_count", wr_cnt, 32'(occ));
        chk("rd_count", rd_cnt, 32'(occ));
        chk("almost_empty", 32'(ae), 32'(occ <= AEL));
        if (m_tvalid) begin
            if (exp_q.size() == 0) begin
                chk("head_unexpected", m_tdata, 32'hFFFF_FFFF ^ m_tdata);
            end else begin
                chk("head_data", m_tdata, exp_q[0]);
                if (m_tready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input bit v, input logic [DW-1:0] d, input bit r);
        s_tvalid = v;
        s_tdata  = d;
        m_tready = r;
    endtask

    task automatic drain(input int n);
        set_in(1'b0, '0, 1'b1);
        repeat (n) cyc();
        set_in(1'b0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        bit            v;
        bit            r;

        // Reset state, then ready one edge after release.
        #12;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_ae", 32'(ae), 32'd1);
        chk("rst_count", wr_cnt, 32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("tready_before_edge", 32'(s_tready), 32'd0);
        cyc();
        chk("tready_after_edge", 32'(s_tready), 32'd1);

        // Fill to full with m_tready low, then an extra word that must drop.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 32'(i), 1'b0);
            cyc();
        end
        chk("full_tready", 32'(s_tready), 32'd0);
        chk("full_count", wr_cnt, 32'(DEPTH));
        set_in(1'b1, 32'hDEAD_BEEF, 1'b0);
        cyc();
        cyc();
        chk("full_count_hold", wr_cnt, 32'(DEPTH));
        drain(DEPTH + 1);
        chk("drained_tvalid", 32'(m_tvalid), 32'd0);
        chk("drained_ae", 32'(ae), 32'd1);

        // Single word latency and almost-empty threshold.
        set_in(1'b1, 32'hA5A5_A5A5, 1'b0);
        cyc();
        set_in(1'b0, '0, 1'b0);
        chk("single_tvalid", 32'(m_tvalid), 32'd1);
        chk("single_tdata", m_tdata, 32'hA5A5_A5A5);
        chk("single_count", wr_cnt, 32'd1);
        chk("single_ae", 32'(ae), 32'd1);
        set_in(1'b1, 32'h5A5A_5A5A, 1'b0);
        cyc();
        set_in(1'b0, '0, 1'b0);
        chk("two_count", wr_cnt, 32'd2);
        chk("two_ae", 32'(ae), 32'd0);
        drain(3);

        // Steady push/pop at occupancy 8; pointers wrap several times.
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 32'h1000 + 32'(i), 1'b0);
            cyc();
        end
        for (int i = 0; i < 40; i++) begin
            set_in(1'b1, 32'h2000 + 32'(i), 1'b1);
            cyc();
            chk("steady_count", wr_cnt, 32'd8);
        end
        drain(9);

        // Randomised traffic, upstream data held until accepted.
        d = $urandom;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            if (i >= 150 && i < 220) r = 1'b0;
            set_in(v, d, r);
            cyc();
            if (wr_acc) d = $urandom;
        end
        drain(DEPTH + 1);

        // Asynchronous reset in the middle of a stream at occupancy 5.
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h3000 + 32'(i), 1'b0);
            cyc();
        end
        set_in(1'b1, 32'h3005, 1'b1);
        chk("pre_reset_count", wr_cnt, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("async_tvalid", 32'(m_tvalid), 32'd0);
        chk("async_tready", 32'(s_tready), 32'd0);
        chk("async_tdata", m_tdata, 32'd0);
        chk("async_ae", 32'(ae), 32'd1);
        chk("async_count", rd_cnt, 32'd0);
        set_in(1'b0, '0, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h4000 + 32'(i), 1'b0);
            cyc();
        end
        set_in(1'b0, '0, 1'b0);
        chk("fresh_count", wr_cnt, 32'd3);
        chk("fresh_head", m_tdata, 32'h4000);
        drain(4);
        chk("final_tvalid", 32'(m_tvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
